// File: rtl/mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mac_pkg                                                   |
// | Brief    : Shared types and default widths for the MAC sequencer     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mac_pkg;

    localparam int c_dw   = 4;
    localparam int c_aw   = 2 * c_dw;
    localparam int c_lenw = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mac_sequencer_if                                          |
// | Brief    : Job control, operand stream and result port bundle        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface mac_sequencer_if
    import mac_pkg::*;
#(
    parameter int DW   = c_dw,
    parameter int AW   = c_aw,
    parameter int LENW = c_lenw
) ();

    logic            start;
    logic [LENW-1:0] len;
    logic            busy;
    logic            a_valid;
    logic            a_ready;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic            res_valid;
    logic            res_ready;
    logic [AW-1:0]   res;
    logic            res_ovf;

    modport master (
        output start, len, a_valid, a, b, res_ready,
        input  busy, a_ready, res_valid, res, res_ovf
    );

    modport slave (
        input  start, len, a_valid, a, b, res_ready,
        output busy, a_ready, res_valid, res, res_ovf
    );

endinterface
`default_nettype wire

// File: rtl/mac_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mac_datapath                                              |
// | Brief    : Registered operand stage feeding a multiply-accumulate    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mac_datapath
    import mac_pkg::*;
#(
    parameter int DW = c_dw,
    parameter int AW = c_aw
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clear,
    input  wire logic          in_valid,
    input  wire logic [DW-1:0] in_a,
    input  wire logic [DW-1:0] in_b,
    output logic               s1_valid,
    output logic [AW-1:0]      acc,
    output logic               ovf
);

    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic            r_valid;
    logic [AW-1:0]   r_acc;
    logic            r_ovf;
    logic [2*DW-1:0] w_prod;
    logic [AW:0]     w_sum;

    assign w_prod = {{DW{1'b0}}, r_a} * {{DW{1'b0}}, r_b};
    // Extra top bit of the sum is the carry that feeds the sticky overflow.
    assign w_sum  = {1'b0, r_acc} + (AW+1)'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_a <= in_a;
                r_b <= in_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_valid) begin
            r_acc <= w_sum[AW-1:0];
            r_ovf <= r_ovf | w_sum[AW];
        end
    end

    assign s1_valid = r_valid;
    assign acc      = r_acc;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mac_sequencer                                             |
// | Brief    : Framed dot-product job controller around mac_datapath     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DW   = c_dw,
    parameter int AW   = c_aw,
    parameter int LENW = c_lenw
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mac_sequencer_if.slave bus
);

    state_t          r_state;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_issued;
    logic            w_accept;
    logic            w_clear;
    logic            w_s1_valid;
    logic [AW-1:0]   w_acc;
    logic            w_ovf;

    assign bus.a_ready = (r_state == RUN) && (r_issued < r_len);
    assign w_accept    = bus.a_valid && bus.a_ready;
    assign w_clear     = (r_state == IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_issued <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_len    <= bus.len;
                        r_issued <= '0;
                        r_state  <= (bus.len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_issued <= r_issued + LENW'(1);
                        if (r_issued + LENW'(1) == r_len) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                // Final pair is in stage 1 on entry; once it has accumulated the sum is final.
                DRAIN: begin
                    if (!w_s1_valid) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mac_datapath #(
        .DW (DW),
        .AW (AW)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .in_valid (w_accept),
        .in_a     (bus.a),
        .in_b     (bus.b),
        .s1_valid (w_s1_valid),
        .acc      (w_acc),
        .ovf      (w_ovf)
    );

    assign bus.busy      = (r_state != IDLE);
    assign bus.res_valid = (r_state == DONE);
    assign bus.res       = w_acc;
    assign bus.res_ovf   = w_ovf;

endmodule
`default_nettype wire
